// File: rtl/dispatcher_seq.sv
// dispatcher_seq: sequences NCH back-to-back capture windows per frame, one per
// correlator channel, with one-shot/continuous modes, abort and a frame counter.
// The end-of-window capture pulse is folded into rst_out to clear the
// downstream accumulators.
module dispatcher_seq #(
   parameter int unsigned CTR_WIDTH  = 32,
   parameter int unsigned FRAME_LEN  = 32'h800,
   parameter int unsigned NCH        = 4,
   parameter int unsigned FCNT_WIDTH = 16,
   localparam int unsigned CH_WIDTH  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  mode,
   input  logic [CTR_WIDTH-1:0]  len_in,
   output logic                  rst_out,
   output logic                  stb,
   output logic                  capture,
   output logic [CH_WIDTH-1:0]   ch_sel,
   output logic [NCH-1:0]        ch_stb,
   output logic                  busy,
   output logic                  done,
   output logic [FCNT_WIDTH-1:0] frame_cnt
);

   // One extra bit so len = 2^CTR_WIDTH-1 cannot wrap the end-of-window compare
   localparam int unsigned CW1 = CTR_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CTR_WIDTH-1:0]  ctr_q, ctr_d;
   logic [CTR_WIDTH-1:0]  len_q, len_d;
   logic                  mode_q, mode_d;
   logic [CH_WIDTH-1:0]   ch_q, ch_d;
   logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

   logic [CW1-1:0]        ctr_p1;
   logic                  win_last;
   logic                  ch_last;

   // Window/channel end detection shared by FSM and datapath
   always_comb begin
      ctr_p1   = {1'b0, ctr_q} + CW1'(1);
      win_last = (ctr_p1 == {1'b0, len_q});
      ch_last  = (ch_q == CH_WIDTH'(NCH - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: abort beats arm; arm only honoured outside RUN
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (win_last && ch_last && !mode_q) begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath next values: window counter, channel, latched config, frame count
   always_comb begin
      ctr_d       = ctr_q;
      ch_d        = ch_q;
      len_d       = len_q;
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      if (abort) begin
         ctr_d = '0;
         ch_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  len_d  = (len_in == '0) ? CTR_WIDTH'(FRAME_LEN) : len_in;
                  mode_d = mode;
                  ctr_d  = '0;
                  ch_d   = '0;
               end
            end
            ST_RUN: begin
               if (win_last) begin
                  ctr_d = '0;
                  if (ch_last) begin
                     ch_d        = '0;
                     frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
                  end else begin
                     ch_d = ch_q + CH_WIDTH'(1);
                  end
               end else begin
                  ctr_d = ctr_p1[CTR_WIDTH-1:0];
               end
            end
            default: begin
               ctr_d = '0;
               ch_d  = '0;
            end
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q       <= '0;
         ch_q        <= '0;
         len_q       <= CTR_WIDTH'(FRAME_LEN);
         mode_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         ctr_q       <= ctr_d;
         ch_q        <= ch_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Outputs decoded from registers; forced to reset values while rst is high
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      stb     = 1'b0;
      capture = 1'b0;
      ch_sel  = '0;
      ch_stb  = '0;
      rst_out = 1'b1;
      if (!rst) begin
         busy    = (state_q == ST_RUN);
         done    = (state_q == ST_DONE);
         stb     = busy && (ctr_q == '0);
         capture = busy && win_last;
         ch_sel  = ch_q;
         ch_stb  = capture ? (NCH'(1) << ch_q) : '0;
         // Abort only pulses the accumulator reset if a window was in flight
         rst_out = capture || (abort && busy);
      end
   end

   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dispatcher_seq.sv
// Directed bench for dispatcher_seq with default parameters (NCH = 4).
module tb_dispatcher_seq;

   localparam int unsigned CTR_WIDTH  = 32;
   localparam int unsigned NCH        = 4;
   localparam int unsigned FCNT_WIDTH = 16;
   localparam int unsigned CH_WIDTH   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  arm;
   logic                  abort;
   logic                  mode;
   logic [CTR_WIDTH-1:0]  len_in;
   logic                  rst_out;
   logic                  stb;
   logic                  capture;
   logic [CH_WIDTH-1:0]   ch_sel;
   logic [NCH-1:0]        ch_stb;
   logic                  busy;
   logic                  done;
   logic [FCNT_WIDTH-1:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int stb_cnt;
   int cap_cnt;

   dispatcher_seq #(
      .CTR_WIDTH (CTR_WIDTH),
      .FRAME_LEN (32'h800),
      .NCH       (NCH),
      .FCNT_WIDTH(FCNT_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .abort    (abort),
      .mode     (mode),
      .len_in   (len_in),
      .rst_out  (rst_out),
      .stb      (stb),
      .capture  (capture),
      .ch_sel   (ch_sel),
      .ch_stb   (ch_stb),
      .busy     (busy),
      .done     (done),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock cycles, sampling on the falling edge and tallying pulses
   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (stb) stb_cnt++;
         if (capture) cap_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; abort = 1'b0; mode = 1'b0; len_in = '0;
      stb_cnt = 0; cap_cnt = 0;

      // ---- reset ----
      tickn(2);
      chk("rst_rst_out", 32'(rst_out), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_stb", 32'(stb), 0);
      rst = 1'b0;
      tickn(1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_rst_out", 32'(rst_out), 0);
      chk("idle_frame_cnt", 32'(frame_cnt), 0);
      chk("idle_ch_sel", 32'(ch_sel), 0);

      // ---- defaults: len 2048, one-shot ----
      arm = 1'b1; stb_cnt = 0; cap_cnt = 0;
      tickn(1);                                   // cycle 1
      arm = 1'b0;
      chk("d_c1_stb", 32'(stb), 1);
      chk("d_c1_busy", 32'(busy), 1);
      chk("d_c1_capture", 32'(capture), 0);
      chk("d_c1_ch_sel", 32'(ch_sel), 0);
      tickn(2046);                                // cycle 2047
      chk("d_c2047_capture", 32'(capture), 0);
      tickn(1);                                   // cycle 2048
      chk("d_c2048_capture", 32'(capture), 1);
      chk("d_c2048_ch_stb", 32'(ch_stb), 32'b0001);
      chk("d_c2048_rst_out", 32'(rst_out), 1);
      tickn(1);                                   // cycle 2049
      chk("d_c2049_stb", 32'(stb), 1);
      chk("d_c2049_ch_sel", 32'(ch_sel), 1);
      chk("d_c2049_rst_out", 32'(rst_out), 0);
      tickn(2047);                                // cycle 4096
      chk("d_c4096_ch_stb", 32'(ch_stb), 32'b0010);
      tickn(1);                                   // cycle 4097
      chk("d_c4097_stb", 32'(stb), 1);
      chk("d_c4097_ch_sel", 32'(ch_sel), 2);
      tickn(2047);                                // cycle 6144
      chk("d_c6144_ch_stb", 32'(ch_stb), 32'b0100);
      tickn(1);                                   // cycle 6145
      chk("d_c6145_stb", 32'(stb), 1);
      tickn(2047);                                // cycle 8192
      chk("d_c8192_ch_stb", 32'(ch_stb), 32'b1000);
      chk("d_c8192_done", 32'(done), 0);
      chk("d_c8192_frame_cnt", 32'(frame_cnt), 0);
      tickn(1);                                   // cycle 8193
      chk("d_c8193_done", 32'(done), 1);
      chk("d_c8193_busy", 32'(busy), 0);
      chk("d_c8193_stb", 32'(stb), 0);
      chk("d_c8193_frame_cnt", 32'(frame_cnt), 1);
      chk("d_stb_count", 32'(stb_cnt), 4);
      chk("d_cap_count", 32'(cap_cnt), 4);

      // ---- len 3, continuous, re-armed from DONE (frame_cnt starts at 1) ----
      len_in = 32'd3; mode = 1'b1; arm = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tickn(1);
         if (k == 1) begin
            arm = 1'b0; len_in = '0; mode = 1'b0;  // changes in RUN are ignored
         end
         chk($sformatf("c_k%0d_stb", k), 32'(stb), 32'((k % 3) == 1));
         chk($sformatf("c_k%0d_capture", k), 32'(capture), 32'((k % 3) == 0));
         chk($sformatf("c_k%0d_ch_sel", k), 32'(ch_sel), 32'(((k - 1) / 3) % 4));
         chk($sformatf("c_k%0d_busy", k), 32'(busy), 1);
         if (k == 24) chk("c_k24_frame_cnt", 32'(frame_cnt), 2);
         if (k == 25) chk("c_k25_frame_cnt", 32'(frame_cnt), 3);
      end

      // ---- rst mid-window (cycle 31: ch 2, ctr 0) ----
      tickn(1);
      rst = 1'b1;
      #1;
      chk("r_now_rst_out", 32'(rst_out), 1);
      chk("r_now_busy", 32'(busy), 0);
      chk("r_now_stb", 32'(stb), 0);
      chk("r_now_ch_sel", 32'(ch_sel), 0);
      tickn(1);
      chk("r_next_rst_out", 32'(rst_out), 1);
      chk("r_next_frame_cnt", 32'(frame_cnt), 0);
      chk("r_next_busy", 32'(busy), 0);
      rst = 1'b0;
      tickn(1);
      chk("r_after_rst_out", 32'(rst_out), 0);
      chk("r_after_busy", 32'(busy), 0);
      chk("r_after_done", 32'(done), 0);
      chk("r_after_stb", 32'(stb), 0);
      chk("r_after_frame_cnt", 32'(frame_cnt), 0);

      // ---- len 1, one-shot ----
      len_in = 32'd1; mode = 1'b0; arm = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tickn(1);
         arm = 1'b0;
         chk($sformatf("l1_k%0d_stb", k), 32'(stb), 1);
         chk($sformatf("l1_k%0d_capture", k), 32'(capture), 1);
         chk($sformatf("l1_k%0d_ch_sel", k), 32'(ch_sel), 32'(k - 1));
         chk($sformatf("l1_k%0d_ch_stb", k), 32'(ch_stb), 32'(1) << (k - 1));
         chk($sformatf("l1_k%0d_rst_out", k), 32'(rst_out), 1);
      end
      chk("l1_k4_frame_cnt", 32'(frame_cnt), 0);
      tickn(1);
      chk("l1_done", 32'(done), 1);
      chk("l1_busy", 32'(busy), 0);
      chk("l1_frame_cnt", 32'(frame_cnt), 1);

      // ---- abort at ch 2, ctr 5 (len 8) ----
      len_in = 32'd8; mode = 1'b1; arm = 1'b1;
      tickn(1);                                   // cycle 1
      arm = 1'b0;
      tickn(21);                                  // cycle 22
      chk("a_ch_sel", 32'(ch_sel), 2);
      chk("a_capture", 32'(capture), 0);
      abort = 1'b1;
      #1;
      chk("a_rst_out", 32'(rst_out), 1);
      tickn(1);
      chk("a_idle_busy", 32'(busy), 0);
      chk("a_idle_done", 32'(done), 0);
      chk("a_idle_ch_sel", 32'(ch_sel), 0);
      chk("a_idle_frame_cnt", 32'(frame_cnt), 1);
      chk("a_idle_rst_out", 32'(rst_out), 0);    // abort held while idle
      abort = 1'b0;

      // ---- re-arm, arm held through RUN, abort on final capture ----
      len_in = 32'd8; mode = 1'b0; arm = 1'b1;
      tickn(1);                                   // cycle 1
      chk("b_c1_stb", 32'(stb), 1);
      chk("b_c1_ch_sel", 32'(ch_sel), 0);
      chk("b_c1_busy", 32'(busy), 1);
      len_in = 32'd5; mode = 1'b1;                // ignored while running
      tickn(7);                                   // cycle 8
      chk("b_c8_capture", 32'(capture), 1);
      chk("b_c8_ch_stb", 32'(ch_stb), 32'b0001);
      tickn(24);                                  // cycle 32
      chk("b_c32_capture", 32'(capture), 1);
      chk("b_c32_ch_sel", 32'(ch_sel), 3);
      chk("b_c32_ch_stb", 32'(ch_stb), 32'b1000);
      abort = 1'b1;
      #1;
      chk("b_abort_capture", 32'(capture), 1);
      chk("b_abort_rst_out", 32'(rst_out), 1);
      tickn(1);
      chk("b_after_busy", 32'(busy), 0);
      chk("b_after_done", 32'(done), 0);
      chk("b_after_frame_cnt", 32'(frame_cnt), 1);
      arm = 1'b0; abort = 1'b0;
      tickn(1);
      chk("b_stay_idle_busy", 32'(busy), 0);
      chk("b_stay_idle_stb", 32'(stb), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dispatcher_seq.md
# dispatcher_seq

Parametrised, multi-channel successor to the single-window dispatcher controller in the correlator datapath. It sequences NCH consecutive capture windows of programmable length, one per correlator channel. For each window it emits a start strobe, a one-hot channel strobe and an end-of-window capture pulse. The capture pulse is folded into rst_out, which resets the downstream accumulators. The block supports one-shot and continuous modes, abort, and a frame counter.

## Interface
- CTR_WIDTH, 32, window counter width
- FRAME_LEN, 2048 (32'h800), default window length used when len_in == 0
- NCH, 4, number of channels per frame (≥1)
- FCNT_WIDTH, 16, frame counter width
- CH_WIDTH, $clog2(NCH) (min 1), channel index width (derived)

- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- arm  in  1  start request; sampled in IDLE and DONE only
- abort  in  1  stop immediately and return to IDLE
- mode  in  1  0 = one-shot (one frame, then DONE); 1 = continuous; latched at arm
- len_in  in  CTR_WIDTH  window length in cycles; latched at arm; 0 selects FRAME_LEN
- rst_out  out  1  rst | capture | abort_ack (combinational)
- stb  out  1  first cycle of each window
- capture  out  1  last cycle of each window
- ch_sel  out  CH_WIDTH  channel of the current window
- ch_stb  out  NCH  one-hot of ch_sel, qualified by capture
- busy  out  1  high in RUN
- done  out  1  high in DONE
- frame_cnt  out  FCNT_WIDTH  completed frames; wraps modulo 2^FCNT_WIDTH

## Operation
- States:
  - IDLE: ctr = 0, ch = 0.
  - RUN: ctr counts 0..len-1 in each window.
  - DONE: holds until arm or rst.
- IDLE/DONE + arm → RUN:
  - len ← (len_in == 0 ? FRAME_LEN : len_in).
  - mode latched.
  - ctr ← 0, ch ← 0.
- RUN, ctr != len-1: ctr ← ctr+1.
- RUN, ctr == len-1 (capture cycle):
  - ch < NCH-1: ch ← ch+1, ctr ← 0.
  - ch == NCH-1: frame_cnt ← frame_cnt+1 (wraps), ch ← 0, ctr ← 0. Next state is RUN if mode = 1, else DONE.
- Counter width rule: next_ctr is computed at CTR_WIDTH+1 bits, so len = 2^CTR_WIDTH-1 does not overflow the compare.
- len = 1: stb and capture are both high every cycle; ch advances every cycle.
- abort in any state:
  - Next state is IDLE; ctr ← 0, ch ← 0.
  - abort_ack = abort & busy, so rst_out is high in the abort cycle only when RUN was active.
  - frame_cnt is not incremented, even if abort coincides with the final capture. That capture still pulses.
- Priority: rst > abort > arm. arm during RUN is ignored; len_in and mode changes during RUN are ignored.
- frame_cnt clears only on rst. Re-arm from DONE does not clear it.

## Timing
- Reset values: state IDLE, ctr 0, ch 0, frame_cnt 0, len FRAME_LEN, mode 0.
- Outputs during rst: stb 0, capture 0, ch_stb 0, busy 0, done 0, ch_sel 0, rst_out 1.
- arm sampled at edge N → state is RUN at N+1 with ctr = 0 and stb = 1 in that cycle. Latency is one cycle.
- stb = (state == RUN) & (ctr == 0). It is registered-derived and glitch-free.
- capture = (state == RUN) & (ctr == len-1). It is combinational from registers.
- Window length is exactly len cycles, stb to capture inclusive. Windows are back-to-back with no gap.
- Frame length is NCH·len cycles.
- One-shot: done rises the cycle after the last capture; busy falls in that same cycle.
- Continuous: the cycle after the last capture has stb = 1 and ch_sel = 0.
- rst_out is high exactly in the rst cycles, the capture cycles, and the abort cycle while busy.

## Test plan
- Defaults (NCH = 4, len_in = 0, mode = 0), arm one cycle:
  - stb at cycles 1, 2049, 4097, 6145; capture at 2048, 4096, 6144, 8192.
  - ch_stb = 0001, 0010, 0100, 1000.
  - done from 8193; frame_cnt = 1.
- len_in = 3, mode = 1, run 30 cycles:
  - capture every 3rd cycle; ch_sel cycles 0,1,2,3,0…
  - frame_cnt = 2 after 24 cycles of RUN.
  - no gap cycles between windows.
- len_in = 1, NCH = 4:
  - stb = capture = 1 every cycle; ch_sel increments every cycle.
  - done after 4 cycles.
- abort at ctr = 5, ch = 2:
  - rst_out = 1 that cycle; IDLE next cycle.
  - frame_cnt unchanged.
  - a subsequent arm restarts at ch = 0, ctr = 0.
- abort coincident with final capture (ch = 3), and arm asserted throughout RUN:
  - capture pulses; frame_cnt unchanged; IDLE next cycle.
  - arm during RUN has no effect.
- rst asserted mid-window with mode = 1:
  - next cycle all outputs at reset values and frame_cnt = 0.
  - rst_out = 1 for each cycle rst is high.
